// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locking arbiter feeding one UART transmitter.
// One tx_start per accepted byte; the next byte is taken only after tx_done.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_done,
  output logic [2:0]           grant_id,
  output logic                 locked
);

  localparam int CW = $clog2(LOCK_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT
  } state_t;

  state_t             state, state_n;
  logic [NUM_REQ-1:0] ready_n;
  logic               start_n;
  logic [7:0]         data_n;
  logic [2:0]         grant_n;
  logic               locked_n;
  logic [CW-1:0]      cnt, cnt_n;

  logic               found;
  logic [2:0]         pick;
  logic [NUM_REQ-1:0] pick_hot;
  logic [NUM_REQ-1:0] own_hot;
  logic               pick_last;
  logic               own_v;
  logic               own_last;
  logic [7:0]         own_data;

  // Lowest index above grant_id wins; else lowest index at or below it.
  always_comb begin
    found = 1'b0;
    pick  = 3'd0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i] && i <= int'(grant_id)) begin
        found = 1'b1;
        pick  = 3'(i);
      end
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i] && i > int'(grant_id)) begin
        found = 1'b1;
        pick  = 3'(i);
      end
    end
  end

  always_comb begin
    pick_hot = '0;
    own_hot  = '0;
    own_data = 8'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pick_hot[i] = (i == int'(pick));
      own_hot[i]  = (i == int'(grant_id));
      if (i == int'(grant_id)) begin
        own_data = req_data[8*i +: 8];
      end
    end
    pick_last = |(req_last & pick_hot);
    own_v     = |(req_valid & own_hot);
    own_last  = |(req_last & own_hot);
  end

  always_comb begin
    state_n  = state;
    ready_n  = '0;
    start_n  = 1'b0;
    data_n   = tx_data;
    grant_n  = grant_id;
    locked_n = locked;
    cnt_n    = cnt;
    unique case (state)
      IDLE: begin
        if (locked) begin
          if (own_v) begin
            ready_n  = own_hot;
            locked_n = ~own_last;
            cnt_n    = '0;
            state_n  = LAUNCH;
          end else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
            locked_n = 1'b0;
            cnt_n    = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end else begin
          cnt_n = '0;
          if (found) begin
            ready_n  = pick_hot;
            grant_n  = pick;
            locked_n = ~pick_last;
            state_n  = LAUNCH;
          end
        end
      end
      // Strobe cycle: requester data is still valid here
      LAUNCH: begin
        start_n = 1'b1;
        data_n  = own_data;
        state_n = WAIT;
      end
      WAIT: begin
        if (tx_done) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      req_ready <= '0;
      tx_start  <= 1'b0;
      tx_data   <= 8'd0;
      grant_id  <= 3'(NUM_REQ - 1);
      locked    <= 1'b0;
      cnt       <= '0;
    end else begin
      state     <= state_n;
      req_ready <= ready_n;
      tx_start  <= start_n;
      tx_data   <= data_n;
      grant_id  <= grant_n;
      locked    <= locked_n;
      cnt       <= cnt_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: queued requesters,
// a fixed-latency UART model and expected {id,byte} order.
module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int TO  = 1024;
  localparam int DLY = 3;

  logic           clk       = 1'b0;
  logic           rst       = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_data  = '0;
  logic [N-1:0]   req_last  = '0;
  logic [N-1:0]   req_ready;
  logic           tx_start;
  logic [7:0]     tx_data;
  logic           tx_done   = 1'b0;
  logic [2:0]     grant_id;
  logic           locked;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ(N),
    .LOCK_TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_last(req_last),
    .req_ready(req_ready),
    .tx_start(tx_start),
    .tx_data(tx_data),
    .tx_done(tx_done),
    .grant_id(grant_id),
    .locked(locked)
  );

  int          n_chk = 0;
  int          n_bad = 0;
  int          cyc   = 0;
  int          busy  = 0;
  int          n_start = 0;
  logic        stray = 1'b0;
  logic [7:0]  hold  = 8'd0;
  logic [10:0] e;
  logic [8:0]  rq[N][$];
  logic [10:0] sb[$];
  int          rdy_log[$];
  int          start_log[$];
  int          done_log[$];
  int          rise[N];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (req_ready[i] && req_valid[i] && rq[i].size() > 0)
        void'(rq[i].pop_front());
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (rq[i].size() > 0) begin
        if (!req_valid[i]) rise[i] = cyc;
        req_valid[i]       = 1'b1;
        req_data[8*i +: 8] = rq[i][0][7:0];
        req_last[i]        = rq[i][0][8];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[8*i +: 8] = 8'd0;
        req_last[i]        = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    tx_done = 1'b0;
    if (rst) begin
      busy = 0;
    end else begin
      if (req_ready != '0) begin
        chk("onehot", $countones(req_ready), 1);
        rdy_log.push_back(cyc);
      end
      if (tx_start) begin
        n_start++;
        start_log.push_back(cyc);
        if (sb.size() == 0) begin
          chk("unexp_start", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          chk("grant", grant_id, e[10:8]);
          chk("data", tx_data, e[7:0]);
        end
        hold = tx_data;
        busy = DLY;
      end else if (busy > 0) begin
        chk("hold", tx_data, hold);
        busy--;
        if (busy == 0) begin
          tx_done = 1'b1;
          done_log.push_back(cyc);
        end
      end
      if (stray) begin
        tx_done = 1'b1;
        stray   = 1'b0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int id, input logic [7:0] d, input logic last);
    rq[id].push_back({last, d});
  endtask

  task automatic expect_tx(input int id, input logic [7:0] d);
    sb.push_back({3'(id), d});
  endtask

  function automatic bit pending();
    bit p;
    p = (sb.size() != 0) || (busy != 0);
    for (int i = 0; i < N; i++) p |= (rq[i].size() != 0);
    return p;
  endfunction

  task automatic drain(input int budget);
    int t;
    t = 0;
    while (pending() && t < budget) begin
      tick(1);
      t++;
    end
    chk("drain_timeout", t < budget, 1);
    tick(4);
  endtask

  task automatic clear_logs();
    rdy_log.delete();
    start_log.delete();
    done_log.delete();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ready"}, req_ready, 0);
    chk({tag, "_start"}, tx_start, 0);
    chk({tag, "_data"}, tx_data, 0);
    chk({tag, "_grant"}, grant_id, N - 1);
    chk({tag, "_locked"}, locked, 0);
  endtask

  initial begin
    int s0;
    int t;
    int ord[4];
    ord = '{3, 0, 1, 2};

    tick(3);
    chk_reset("rst");
    rst = 1'b0;
    tick(2);
    chk("idle_ready", req_ready, 0);
    chk("idle_start", tx_start, 0);

    // 1: req0 first after reset, then req2
    s0 = n_start;
    push(0, 8'h55, 1'b1);
    push(2, 8'hA3, 1'b1);
    expect_tx(0, 8'h55);
    expect_tx(2, 8'hA3);
    drain(200);
    chk("t1_starts", n_start - s0, 2);

    // 2: all valid, single-byte; rotation continues from grant 2
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < N; i++)
        push(i, 8'(i * 16 + r), 1'b1);
    for (int r = 0; r < 3; r++)
      for (int k = 0; k < 4; k++)
        expect_tx(ord[k], 8'(ord[k] * 16 + r));
    drain(500);

    // 3: req1 3-byte packet is not interleaved
    push(0, 8'hC0, 1'b1);
    push(2, 8'hC2, 1'b1);
    push(1, 8'hB1, 1'b0);
    push(1, 8'hB2, 1'b0);
    push(1, 8'hB3, 1'b1);
    expect_tx(0, 8'hC0);
    expect_tx(1, 8'hB1);
    expect_tx(1, 8'hB2);
    expect_tx(1, 8'hB3);
    expect_tx(2, 8'hC2);
    drain(500);

    // 4: stalled owner loses its lock after the timeout, twice
    clear_logs();
    push(3, 8'hD3, 1'b0);
    push(0, 8'hD0, 1'b0);
    push(1, 8'hD1, 1'b1);
    expect_tx(3, 8'hD3);
    expect_tx(0, 8'hD0);
    expect_tx(1, 8'hD1);
    t = 0;
    while (done_log.size() == 0 && t < 100) begin
      tick(1);
      t++;
    end
    tick(10);
    chk("t4_locked", locked, 1);
    chk("t4_owner", grant_id, 3);
    drain(5000);
    chk("t4_nrdy", rdy_log.size(), 3);
    if (rdy_log.size() == 3 && done_log.size() >= 2) begin
      chk("t4_gap1", rdy_log[1] - done_log[0], TO + 2);
      chk("t4_gap2", rdy_log[2] - done_log[1], TO + 2);
    end
    chk("t4_unlocked", locked, 0);

    // 5: latency and back-to-back bytes
    clear_logs();
    push(1, 8'hE1, 1'b0);
    push(1, 8'hE2, 1'b1);
    expect_tx(1, 8'hE1);
    expect_tx(1, 8'hE2);
    drain(200);
    chk("t5_nrdy", rdy_log.size(), 2);
    if (rdy_log.size() == 2 && start_log.size() >= 1 &&
        done_log.size() >= 1) begin
      chk("t5_ready_lat", rdy_log[0] - rise[1], 1);
      chk("t5_start_lat", start_log[0] - rise[1], 2);
      chk("t5_next_acc", rdy_log[1] - done_log[0], 2);
    end

    // 6: reset while waiting for tx_done
    clear_logs();
    push(2, 8'hF2, 1'b1);
    expect_tx(2, 8'hF2);
    t = 0;
    while (start_log.size() == 0 && t < 100) begin
      tick(1);
      t++;
    end
    chk("t6_started", start_log.size(), 1);
    tick(1);
    rst = 1'b1;
    tick(1);
    chk_reset("t6");
    rst   = 1'b0;
    stray = 1'b1;
    s0    = n_start;
    tick(4);
    chk("t6_no_start", n_start - s0, 0);
    push(1, 8'hA1, 1'b1);
    push(0, 8'hA0, 1'b1);
    expect_tx(0, 8'hA0);
    expect_tx(1, 8'hA1);
    drain(200);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog");
    $fatal(1);
  end

endmodule
